// File: rtl/vx_ifetch_unit.sv
// ---------------------------------------------------------------------------
// vx_ifetch_unit
// Instruction fetch unit. The warp scheduler sends one fetch request per warp.
// The request goes on to the instruction cache tagged with the warp id, and
// the unit keeps that warp's pc and thread mask in a small table. Cache
// responses may come back in any order. Each response is matched to its warp
// through the tag and passed on to decode together with the saved metadata.
// A warp can have at most one fetch in flight. A request for a warp that is
// already pending is stalled and is not forwarded to the cache.
//
// Configuration macro: IFETCH_RSP_BUFFER_EN
//   undefined : combinational response path (0-cycle latency)
//   defined   : 2-entry registered response FIFO (1-cycle latency)
//
// Ports
//   clk, reset              clock (rising edge), async active-low reset
//   ifetch_req_*            fetch request from the warp scheduler
//   icache_req_*            word-address request to the instruction cache
//   icache_rsp_*            cache response, tagged with the warp id
//   ifetch_rsp_*            fetch response to decode
//   pending_mask            warps that have a fetch outstanding
//   busy                    some fetch is outstanding or a response is buffered
// ---------------------------------------------------------------------------
module vx_ifetch_unit #(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    localparam int NWB        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ifetch_req_valid,
    output logic                   ifetch_req_ready,
    input  logic [NWB-1:0]         ifetch_req_wid,
    input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
    input  logic [31:0]            ifetch_req_pc,

    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [29:0]            icache_req_addr,
    output logic [NWB-1:0]         icache_req_tag,

    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [31:0]            icache_rsp_data,
    input  logic [NWB-1:0]         icache_rsp_tag,

    output logic                   ifetch_rsp_valid,
    input  logic                   ifetch_rsp_ready,
    output logic [NWB-1:0]         ifetch_rsp_wid,
    output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
    output logic [31:0]            ifetch_rsp_pc,
    output logic [31:0]            ifetch_rsp_instr,

    output logic [NUM_WARPS-1:0]   pending_mask,
    output logic                   busy
);

    // CORE_ID is informational only.
    logic [31:0] unused_core_id;
    assign unused_core_id = 32'(CORE_ID);

    logic [NUM_WARPS-1:0]   pending_q, pending_d;
    logic [31:0]            pc_tbl_q    [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_tbl_q [NUM_WARPS];

    logic req_pend, rsp_pend;
    logic req_fire, rsp_hit;

    assign req_pend = pending_q[ifetch_req_wid];
    assign rsp_pend = pending_q[icache_rsp_tag];

    // pending_q is already clear during reset. The extra reset gate keeps the
    // cache request quiet while reset is held, even if the scheduler is still
    // driving valid.
    assign icache_req_valid = reset & ifetch_req_valid & ~req_pend;
    assign ifetch_req_ready = reset & icache_req_ready & ~req_pend;
    assign icache_req_addr  = ifetch_req_pc[31:2];
    assign icache_req_tag   = ifetch_req_wid;

    assign req_fire = ifetch_req_valid & ifetch_req_ready;
    // A response for a warp that is not pending is still accepted. It is
    // dropped here because rsp_hit stays low for it.
    assign rsp_hit  = icache_rsp_valid & icache_rsp_ready & rsp_pend;

    // A warp cannot fire and retire in the same cycle: firing needs its
    // pending bit clear, and retiring needs it set. So the set and the clear
    // always hit different bits.
    always_comb begin
        pending_d = pending_q;
        if (rsp_hit)  pending_d[icache_rsp_tag] = 1'b0;
        if (req_fire) pending_d[ifetch_req_wid] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only. Blocking
    // assignments here would create read-after-write races between flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // NOTE: the metadata table has no reset. Each entry is written before it
    // can be read, because a read needs the pending bit that the same fire sets.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_tbl_q[ifetch_req_wid]    <= ifetch_req_pc;
            tmask_tbl_q[ifetch_req_wid] <= ifetch_req_tmask;
        end
    end

    assign pending_mask = pending_q;

`ifdef IFETCH_RSP_BUFFER_EN
    typedef struct packed {
        logic [NWB-1:0]         wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic [31:0]            instr;
    } rsp_entry_t;

    rsp_entry_t fifo_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       pop;

    assign icache_rsp_ready = (count_q != 2'd2);
    assign ifetch_rsp_valid = (count_q != 2'd0);
    assign pop              = ifetch_rsp_valid & ifetch_rsp_ready;

    // Full throughput: a push and a pop in the same cycle leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ rsp_hit;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, rsp_hit} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_hit) begin
            fifo_q[wr_ptr_q] <= '{wid:   icache_rsp_tag,
                                  tmask: tmask_tbl_q[icache_rsp_tag],
                                  pc:    pc_tbl_q[icache_rsp_tag],
                                  instr: icache_rsp_data};
        end
    end

    assign ifetch_rsp_wid   = fifo_q[rd_ptr_q].wid;
    assign ifetch_rsp_tmask = fifo_q[rd_ptr_q].tmask;
    assign ifetch_rsp_pc    = fifo_q[rd_ptr_q].pc;
    assign ifetch_rsp_instr = fifo_q[rd_ptr_q].instr;

    assign busy = (|pending_q) | (count_q != 2'd0);
`else
    // Pass-through path. Stray responses are always accepted. Real responses
    // are accepted only when decode can take them, so payload stability under
    // backpressure comes from the cache holding its response.
    assign ifetch_rsp_valid = icache_rsp_valid & rsp_pend;
    assign icache_rsp_ready = ifetch_rsp_ready | ~rsp_pend;
    assign ifetch_rsp_wid   = icache_rsp_tag;
    assign ifetch_rsp_tmask = tmask_tbl_q[icache_rsp_tag];
    assign ifetch_rsp_pc    = pc_tbl_q[icache_rsp_tag];
    assign ifetch_rsp_instr = icache_rsp_data;

    assign busy = |pending_q;
`endif

endmodule

// File: tb/tb_vx_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_vx_ifetch_unit
// Directed and random stimulus for vx_ifetch_unit. The reference model keeps
// three things:
//   - a pending flag per warp,
//   - the metadata each warp last launched with,
//   - a queue of responses owed to decode.
// Every cycle the DUT outputs are compared with what the model predicts.
// The model follows whichever response-path build IFETCH_RSP_BUFFER_EN selects.
// ---------------------------------------------------------------------------
module tb_vx_ifetch_unit;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int NWB = 2;

    logic            clk;
    logic            reset;
    logic            ifetch_req_valid, ifetch_req_ready;
    logic [NWB-1:0]  ifetch_req_wid;
    logic [NT-1:0]   ifetch_req_tmask;
    logic [31:0]     ifetch_req_pc;
    logic            icache_req_valid, icache_req_ready;
    logic [29:0]     icache_req_addr;
    logic [NWB-1:0]  icache_req_tag;
    logic            icache_rsp_valid, icache_rsp_ready;
    logic [31:0]     icache_rsp_data;
    logic [NWB-1:0]  icache_rsp_tag;
    logic            ifetch_rsp_valid, ifetch_rsp_ready;
    logic [NWB-1:0]  ifetch_rsp_wid;
    logic [NT-1:0]   ifetch_rsp_tmask;
    logic [31:0]     ifetch_rsp_pc;
    logic [31:0]     ifetch_rsp_instr;
    logic [NW-1:0]   pending_mask;
    logic            busy;

    vx_ifetch_unit #(.CORE_ID(0), .NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
        .clk              (clk),
        .reset            (reset),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_ready (ifetch_req_ready),
        .ifetch_req_wid   (ifetch_req_wid),
        .ifetch_req_tmask (ifetch_req_tmask),
        .ifetch_req_pc    (ifetch_req_pc),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_req_tag   (icache_req_tag),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_ready (icache_rsp_ready),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_tag   (icache_rsp_tag),
        .ifetch_rsp_valid (ifetch_rsp_valid),
        .ifetch_rsp_ready (ifetch_rsp_ready),
        .ifetch_rsp_wid   (ifetch_rsp_wid),
        .ifetch_rsp_tmask (ifetch_rsp_tmask),
        .ifetch_rsp_pc    (ifetch_rsp_pc),
        .ifetch_rsp_instr (ifetch_rsp_instr),
        .pending_mask     (pending_mask),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [NWB-1:0] wid;
        logic [NT-1:0]  tm;
        logic [31:0]    pc;
        logic [31:0]    instr;
    } rsp_t;

    bit          m_pend [NW];
    logic [31:0] m_pc   [NW];
    logic [NT-1:0] m_tm [NW];
    rsp_t        m_q    [$];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_pend[w] = 1'b0;
        m_q.delete();
    endtask

    task automatic set_req(input bit v, input int wid, input logic [NT-1:0] tm, input logic [31:0] pc);
        ifetch_req_valid = v;
        ifetch_req_wid   = NWB'(wid);
        ifetch_req_tmask = tm;
        ifetch_req_pc    = pc;
    endtask

    task automatic set_rsp(input bit v, input int tag, input logic [31:0] data);
        icache_rsp_valid = v;
        icache_rsp_tag   = NWB'(tag);
        icache_rsp_data  = data;
    endtask

    // One clock cycle. The current inputs are checked at the falling edge
    // against the model, the model is advanced, and the task returns 1 time
    // unit after the next rising edge.
    task automatic cycle();
        bit rp, sp, exp_v, exp_rdy, req_f, rsp_acc, pop;
        logic [NW-1:0] pm;
        rsp_t e;
        @(negedge clk);
        rp = m_pend[ifetch_req_wid];
        sp = m_pend[icache_rsp_tag];
        pm = '0;
        for (int w = 0; w < NW; w++) pm[w] = m_pend[w];
        check("pending_mask", 64'(pending_mask), 64'(pm));
        check("busy", 64'(busy), 64'((pm != 0) || (m_q.size() > 0)));
        check("icache_req_valid", 64'(icache_req_valid), 64'(ifetch_req_valid & !rp));
        check("ifetch_req_ready", 64'(ifetch_req_ready), 64'(icache_req_ready & !rp));
        check("icache_req_addr", 64'(icache_req_addr), 64'(ifetch_req_pc >> 2));
        check("icache_req_tag", 64'(icache_req_tag), 64'(ifetch_req_wid));
`ifdef IFETCH_RSP_BUFFER_EN
        exp_rdy = (m_q.size() < 2);
        exp_v   = (m_q.size() > 0);
        e       = exp_v ? m_q[0] : '{'0, '0, '0, '0};
`else
        exp_rdy = ifetch_rsp_ready | !sp;
        exp_v   = icache_rsp_valid & sp;
        e       = '{icache_rsp_tag, m_tm[icache_rsp_tag], m_pc[icache_rsp_tag], icache_rsp_data};
`endif
        check("icache_rsp_ready", 64'(icache_rsp_ready), 64'(exp_rdy));
        check("ifetch_rsp_valid", 64'(ifetch_rsp_valid), 64'(exp_v));
        if (exp_v) begin
            check("rsp_wid", 64'(ifetch_rsp_wid), 64'(e.wid));
            check("rsp_tmask", 64'(ifetch_rsp_tmask), 64'(e.tm));
            check("rsp_pc", 64'(ifetch_rsp_pc), 64'(e.pc));
            check("rsp_instr", 64'(ifetch_rsp_instr), 64'(e.instr));
        end
        req_f   = ifetch_req_valid & icache_req_ready & !rp;
        rsp_acc = icache_rsp_valid & exp_rdy & sp;
        pop     = exp_v & ifetch_rsp_ready;
`ifdef IFETCH_RSP_BUFFER_EN
        if (pop) void'(m_q.pop_front());
        if (rsp_acc)
            m_q.push_back('{icache_rsp_tag, m_tm[icache_rsp_tag], m_pc[icache_rsp_tag], icache_rsp_data});
`else
        pop = pop & 1'b1;
`endif
        if (rsp_acc) m_pend[icache_rsp_tag] = 1'b0;
        if (req_f) begin
            m_pend[ifetch_req_wid] = 1'b1;
            m_pc[ifetch_req_wid]   = ifetch_req_pc;
            m_tm[ifetch_req_wid]   = ifetch_req_tmask;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        set_req(1'b0, 0, '0, '0);
        set_rsp(1'b0, 0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset: outputs must be quiet even with a request being driven.
        model_reset();
        reset            = 1'b0;
        icache_req_ready = 1'b1;
        ifetch_rsp_ready = 1'b1;
        set_req(1'b1, 1, 4'hF, 32'h0000_0100);
        set_rsp(1'b0, 0, '0);
        #2;
        check("reset_pending_mask", 64'(pending_mask), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_ifetch_rsp_valid", 64'(ifetch_rsp_valid), 64'h0);
        check("reset_icache_req_valid", 64'(icache_req_valid), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic fetch, issued in the first cycle after reset.
        set_req(1'b1, 1, 4'hF, 32'h8000_0010);
        #1;
        check("basic_addr", 64'(icache_req_addr), 64'h2000_0004);
        check("basic_first_ready", 64'(ifetch_req_ready), 64'h1);
        cycle();
        check("basic_pending", 64'(pending_mask), 64'h2);
        set_req(1'b0, 0, '0, '0);
        set_rsp(1'b1, 1, 32'h0000_0013);
        cycle();
        check("basic_pending_clear", 64'(pending_mask), 64'h0);
        idle(2);

        // Out-of-order responses.
        set_req(1'b1, 0, 4'h3, 32'h0000_1000);
        cycle();
        set_req(1'b1, 2, 4'hC, 32'h0000_2004);
        cycle();
        set_req(1'b0, 0, '0, '0);
        check("ooo_pending_5", 64'(pending_mask), 64'h5);
        set_rsp(1'b1, 2, 32'hAAAA_0002);
        cycle();
        check("ooo_pending_1", 64'(pending_mask), 64'h1);
        set_rsp(1'b1, 0, 32'hAAAA_0000);
        cycle();
        check("ooo_pending_0", 64'(pending_mask), 64'h0);
        idle(2);

        // Duplicate request for a pending warp.
        set_req(1'b1, 3, 4'h5, 32'h0000_3000);
        cycle();
        set_req(1'b1, 3, 4'hA, 32'h0000_3100);
        #1;
        check("dup_no_fwd", 64'(icache_req_valid), 64'h0);
        check("dup_ready", 64'(ifetch_req_ready), 64'h0);
        for (int i = 0; i < 3; i++) cycle();
        set_rsp(1'b1, 3, 32'h1234_5678);
        cycle();
        set_rsp(1'b0, 0, '0);
        cycle();
        set_req(1'b0, 0, '0, '0);
        set_rsp(1'b1, 3, 32'h8765_4321);
        cycle();
        idle(2);

        // Same-cycle fire and retire on different warps.
        set_req(1'b1, 0, 4'h1, 32'h0000_4000);
        cycle();
        set_req(1'b1, 1, 4'h2, 32'h0000_5000);
        set_rsp(1'b1, 0, 32'h0000_00AA);
        cycle();
        check("same_cycle_pending", 64'(pending_mask), 64'h2);
        set_req(1'b0, 0, '0, '0);
        set_rsp(1'b1, 1, 32'h0000_00BB);
        cycle();
        idle(2);

        // Backpressure from decode.
        set_req(1'b1, 1, 4'h9, 32'h0000_6000);
        cycle();
        set_req(1'b1, 2, 4'h6, 32'h0000_7000);
        cycle();
        set_req(1'b0, 0, '0, '0);
        ifetch_rsp_ready = 1'b0;
        set_rsp(1'b1, 1, 32'hCAFE_0001);
        for (int i = 0; i < 5; i++) cycle();
        set_rsp(1'b1, 2, 32'hCAFE_0002);
        cycle();
        set_rsp(1'b1, 0, 32'hCAFE_0000);
        cycle();
        ifetch_rsp_ready = 1'b1;
        set_rsp(1'b1, 1, 32'hCAFE_0001);
        cycle();
        set_rsp(1'b1, 2, 32'hCAFE_0002);
        cycle();
        idle(3);

        // Stray response.
        set_rsp(1'b1, 2, 32'hDEAD_BEEF);
        #1;
        check("stray_ready", 64'(icache_rsp_ready), 64'h1);
        check("stray_no_valid", 64'(ifetch_rsp_valid), 64'h0);
        cycle();
        check("stray_state", 64'(pending_mask), 64'h0);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 1) == 1, int'($urandom_range(0, NW - 1)),
                    NT'($urandom), $urandom);
            icache_req_ready = ($urandom_range(0, 3) != 0);
            set_rsp($urandom_range(0, 1) == 1, int'($urandom_range(0, NW - 1)), $urandom);
            ifetch_rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        icache_req_ready = 1'b1;
        ifetch_rsp_ready = 1'b1;
        idle(1);
        for (int w = 0; w < NW; w++) begin
            set_rsp(1'b1, w, 32'h0F0F_0000 + 32'(w));
            cycle();
        end
        idle(3);

        // Reset in the middle of operation: warps 0, 1 and 2 are launched,
        // then a response for warp 2 is held while decode is stalled.
        set_req(1'b1, 0, 4'h1, 32'h0000_8000);
        cycle();
        set_req(1'b1, 1, 4'h2, 32'h0000_9000);
        cycle();
        set_req(1'b1, 2, 4'h4, 32'h0000_A000);
        cycle();
        set_req(1'b0, 0, '0, '0);
        ifetch_rsp_ready = 1'b0;
        set_rsp(1'b1, 2, 32'h5555_0002);
        cycle();
        check("midreset_busy_before", 64'(busy), 64'h1);
        set_rsp(1'b0, 0, '0);
        set_req(1'b1, 3, 4'hF, 32'h0000_B000);
        reset = 1'b0;
        #1;
        check("midreset_pending_mask", 64'(pending_mask), 64'h0);
        check("midreset_busy", 64'(busy), 64'h0);
        check("midreset_ifetch_rsp_valid", 64'(ifetch_rsp_valid), 64'h0);
        check("midreset_icache_req_valid", 64'(icache_req_valid), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        ifetch_rsp_ready = 1'b1;
        cycle();
        check("post_reset_accept", 64'(pending_mask), 64'h8);
        set_req(1'b0, 0, '0, '0);
        set_rsp(1'b1, 3, 32'h7777_0003);
        cycle();
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
